// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT event counters with a software write port, sticky overflow flags and snapshot shadows.
// Read data and valid are registered one cycle after rd_en; there is no backpressure, a read is accepted every cycle.
module perf_counter_bank #(
  parameter int WIDTH    = 32,
  parameter int NUM_CNT  = 4,
  parameter int IDX_W    = 2,
  parameter int SATURATE = 0
) (
  input  logic               clk,
  input  logic               counter_rst,
  input  logic               counter_stop,
  input  logic [NUM_CNT-1:0] evt,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               snap,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_shadow,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic [NUM_CNT-1:0] ovf,
  output logic               ovf_any
);

  logic [WIDTH-1:0]   cnt_q    [NUM_CNT];
  logic [WIDTH-1:0]   cnt_d    [NUM_CNT];
  logic [WIDTH-1:0]   shadow_q [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_d;
  logic [WIDTH-1:0]   rd_sel;

  // A software write beats a same-cycle event; the event is simply lost.
  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        cnt_d[i] = wr_data;
        ovf_d[i] = 1'b0;
      end else if (evt[i] && !counter_stop) begin
        if (&cnt_q[i]) begin
          cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // Indices with no matching channel fall through to zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_sel = rd_shadow ? shadow_q[i] : cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (counter_rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf      <= '0;
      ovf_any  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap) begin
          shadow_q[i] <= cnt_q[i];
        end
      end
      ovf      <= ovf_d;
      ovf_any  <= |ovf_d;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Drives a wrapping 4-channel bank and a saturating 3-channel bank with identical stimulus
// and scores both against an array-based model of the counter rules.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        counter_rst = 1'b0, counter_stop = 1'b0;
  logic [3:0]  evt = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic        snap = 1'b0, rd_en = 1'b0, rd_shadow = 1'b0;
  logic [2:0]  rd_idx = '0;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, ovf_any0, ovf_any1;
  logic [3:0]  ovf0;
  logic [2:0]  ovf1;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(32), .NUM_CNT(4), .IDX_W(3), .SATURATE(0)) dut0 (
    .clk(clk), .counter_rst(counter_rst), .counter_stop(counter_stop), .evt(evt),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .snap(snap),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_shadow(rd_shadow),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .ovf(ovf0), .ovf_any(ovf_any0));

  perf_counter_bank #(.WIDTH(32), .NUM_CNT(3), .IDX_W(2), .SATURATE(1)) dut1 (
    .clk(clk), .counter_rst(counter_rst), .counter_stop(counter_stop), .evt(evt[2:0]),
    .wr_en(wr_en), .wr_idx(wr_idx[1:0]), .wr_data(wr_data), .snap(snap),
    .rd_en(rd_en), .rd_idx(rd_idx[1:0]), .rd_shadow(rd_shadow),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .ovf(ovf1), .ovf_any(ovf_any1));

  localparam logic [31:0] MAXV = 32'hFFFF_FFFF;
  int          num_ch [2] = '{4, 3};
  int          sat    [2] = '{0, 1};
  logic [31:0] m_cnt  [2][8];
  logic [31:0] m_sh   [2][8];
  bit          m_ovf  [2][8];
  logic [31:0] m_rd   [2];
  bit          m_vld  [2];
  logic [31:0] q0[$], q1[$];

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and advance the model by the same edge.
  task automatic step(input bit rst, input bit stop, input logic [3:0] ev, input bit we,
                      input logic [2:0] widx, input logic [31:0] wd, input bit sn,
                      input bit re, input logic [2:0] ridx, input bit rsh);
    @(negedge clk);
    #1;
    counter_rst = rst; counter_stop = stop; evt = ev; wr_en = we; wr_idx = widx;
    wr_data = wd; snap = sn; rd_en = re; rd_idx = ridx; rd_shadow = rsh;
    for (int d = 0; d < 2; d++) begin
      int wi, ri;
      logic [31:0] v;
      wi = (d == 0) ? int'(widx) : int'(widx[1:0]);
      ri = (d == 0) ? int'(ridx) : int'(ridx[1:0]);
      m_vld[d] = 1'b0;
      if (rst) begin
        for (int i = 0; i < 8; i++) begin
          m_cnt[d][i] = 0; m_sh[d][i] = 0; m_ovf[d][i] = 0;
        end
        m_rd[d] = 0;
      end else begin
        if (re) begin
          v = 0;
          if (ri < num_ch[d]) v = rsh ? m_sh[d][ri] : m_cnt[d][ri];
          m_rd[d] = v;
          m_vld[d] = 1'b1;
          if (d == 0) q0.push_back(v); else q1.push_back(v);
        end
        for (int i = 0; i < num_ch[d]; i++) begin
          if (sn) m_sh[d][i] = m_cnt[d][i];
          if (we && wi == i) begin
            m_cnt[d][i] = wd;
            m_ovf[d][i] = 0;
          end else if (ev[i] && !stop) begin
            if (m_cnt[d][i] == MAXV) begin
              m_cnt[d][i] = (sat[d] != 0) ? MAXV : 32'd0;
              m_ovf[d][i] = 1;
            end else begin
              m_cnt[d][i] = m_cnt[d][i] + 32'd1;
            end
          end
        end
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 0, 3'd0, 32'd0, 0, 0, 3'd0, 0);
  endtask

  task automatic rd(input logic [2:0] idx, input bit sh);
    step(0, 0, 4'h0, 0, 3'd0, 32'd0, 0, 1, idx, sh);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] v);
    step(0, 0, 4'h0, 1, idx, v, 0, 0, 3'd0, 0);
  endtask

  // Monitor: every returned read is popped from the scoreboard; flags and held data are checked each cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        logic        vld, oa;
        logic [31:0] dat, e;
        logic [3:0]  ov, eov;
        vld = (d == 0) ? rd_valid0 : rd_valid1;
        dat = (d == 0) ? rd_data0 : rd_data1;
        ov  = (d == 0) ? ovf0 : {1'b0, ovf1};
        oa  = (d == 0) ? ovf_any0 : ovf_any1;
        eov = '0;
        for (int i = 0; i < num_ch[d]; i++) eov[i] = m_ovf[d][i];
        chk("rd_valid", d, {31'd0, vld}, {31'd0, m_vld[d]});
        if (vld) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk("rd_valid_without_request", d, 32'd1, 32'd0);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("rd_data_returned", d, dat, e);
          end
        end
        chk("rd_data_held", d, dat, m_rd[d]);
        chk("ovf", d, {28'd0, ov}, {28'd0, eov});
        chk("ovf_any", d, {31'd0, oa}, {31'd0, |eov});
      end
    end
  end

  initial begin
    step(1, 0, 4'h0, 0, 3'd0, 32'd0, 0, 0, 3'd0, 0);
    chk_on = 1'b1;
    for (int i = 0; i < 4; i++) rd(3'(i), 0);
    for (int i = 0; i < 4; i++) rd(3'(i), 1);

    // Two channels counting ten events.
    for (int c = 0; c < 10; c++) step(0, 0, 4'b0101, 0, 3'd0, 32'd0, 0, 0, 3'd0, 0);
    for (int i = 0; i < 4; i++) rd(3'(i), 0);

    // Global stop freezes three of eight events.
    for (int c = 1; c <= 8; c++) step(0, (c >= 3 && c <= 5), 4'b0010, 0, 3'd0, 32'd0, 0, 0, 3'd0, 0);
    rd(3'd1, 0);

    // Crossing all-ones: wrap on dut0, saturate on dut1; write clears the flag.
    wr(3'd2, 32'hFFFF_FFFE);
    for (int c = 0; c < 3; c++) step(0, 0, 4'b0100, 0, 3'd0, 32'd0, 0, 0, 3'd0, 0);
    rd(3'd2, 0);
    idle();
    wr(3'd2, 32'd0);
    rd(3'd2, 0);

    // Snapshot captures pre-edge values while events and writes land live.
    wr(3'd0, 32'd100);
    step(0, 0, 4'b0001, 0, 3'd0, 32'd0, 1, 0, 3'd0, 0);
    idle();
    rd(3'd0, 1);
    rd(3'd0, 0);
    step(0, 0, 4'b0000, 1, 3'd0, 32'd7, 1, 0, 3'd0, 0);
    rd(3'd0, 1);
    rd(3'd0, 0);

    // Write beats a same-edge event; out-of-range accesses.
    step(0, 0, 4'b0001, 1, 3'd0, 32'd50, 0, 0, 3'd0, 0);
    rd(3'd0, 0);
    wr(3'd3, 32'h1234_5678);
    rd(3'd3, 0);
    wr(3'd5, 32'hDEAD_BEEF);
    rd(3'd5, 0);
    rd(3'd7, 1);

    // Reset directly behind a read drops nothing already returned and clears everything.
    step(0, 0, 4'b1111, 0, 3'd0, 32'd0, 1, 1, 3'd0, 0);
    step(1, 0, 4'b1111, 1, 3'd1, 32'd9, 1, 1, 3'd1, 0);
    idle();
    for (int i = 0; i < 4; i++) rd(3'(i), 0);
    for (int i = 0; i < 4; i++) rd(3'(i), 1);

    // Randomized traffic, with writes biased near all-ones to reach overflow.
    for (int c = 0; c < 600; c++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0), 4'($urandom),
           ($urandom_range(0, 5) == 0), 3'($urandom), wd, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 0), 3'($urandom), 1'($urandom));
    end
    idle();
    idle();
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 0, 32'(q0.size()), 32'd0);
    chk("scoreboard_drained", 1, 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Bank of NUM_CNT independent event counters. It is the parametrised successor to the single free-running instruction counter and feeds the core's CSR and performance-monitoring read path. Each channel does the following:
- counts its own event strobe, gated by a global stop;
- has a software write port;
- keeps a sticky overflow flag;
- selects wrap or saturate behaviour at elaboration time.

A snapshot strobe copies all live counters into shadow registers, so software can read a coherent set. Reads are registered with 1-cycle latency.

Parameters:
WIDTH, 32, counter width in bits (matches XLEN).
NUM_CNT, 4, number of counter channels (1..16).
IDX_W, 2, index width; NUM_CNT <= 2**IDX_W is required.
SATURATE, 0, 0 = counters wrap to 0 past all-ones; 1 = counters hold at all-ones.

Ports:
clk  in  1  clock; all state updates on posedge.
counter_rst  in  1  synchronous active-high reset.
counter_stop  in  1  global freeze; while 1, no channel increments.
evt  in  NUM_CNT  per-channel increment strobe; bit i adds 1 to counter i this cycle.
wr_en  in  1  software write strobe.
wr_idx  in  IDX_W  channel to write.
wr_data  in  WIDTH  value to load.
snap  in  1  copy all live counters to shadow registers.
rd_en  in  1  read request.
rd_idx  in  IDX_W  channel to read.
rd_shadow  in  1  0 = read live counter, 1 = read shadow register.
rd_data  out  WIDTH  registered read data.
rd_valid  out  1  high exactly one cycle after an accepted rd_en.
ovf  out  NUM_CNT  sticky overflow flag per channel.
ovf_any  out  1  OR-reduction of ovf, registered with ovf.

Behaviour:
Reset:
- counter_rst = 1 at a posedge clears all live counters, shadows, ovf, rd_data and rd_valid to 0.
- It overrides every other input that cycle.
- Asserting it mid-read drops the pending rd_valid: rd_valid is 0 on the next cycle.

Per-channel update priority, evaluated each posedge for channel i:
- counter_rst: clear.
- wr_en && wr_idx == i: load wr_data and clear ovf[i]. A simultaneous evt[i] is discarded.
- evt[i] && !counter_stop: increment.
- Otherwise hold.

Increment:
- If the counter is not all-ones: count + 1.
- If the counter is all-ones and SATURATE = 0: the counter becomes 0 and ovf[i] is set.
- If the counter is all-ones and SATURATE = 1: the counter holds all-ones and ovf[i] is set.
- ovf[i] stays set until a write to channel i or counter_rst.

Channel independence:
- All channels update in parallel within one cycle.
- Multiple evt bits may be high together.

Snapshot:
- snap = 1 loads every shadow[i] with the live counter[i] value held before this edge.
- A simultaneous write or increment does not affect the captured value; it lands in the live counter only.
- Shadows change only on snap or counter_rst.

Read:
- rd_en at edge N makes rd_data hold the selected register's pre-edge-N value from edge N onward, with rd_valid = 1 for that cycle.
- rd_data holds its value when rd_en = 0; rd_valid is 0.
- Back-to-back reads are allowed every cycle.

Out-of-range index (idx >= NUM_CNT):
- Writes are ignored.
- Reads return 0 with rd_valid = 1.

ovf_any:
- Updates the same edge as ovf.
- Is 0 after reset.

No combinational path exists from any input to any output.

Test Plan:
1. Reset, then evt = 4'b0101 for 10 cycles with counter_stop = 0 → read ch0 = 10, ch1 = 0, ch2 = 10, ch3 = 0; each rd_valid comes 1 cycle after its rd_en.
2. evt[1] held for 8 cycles with counter_stop = 1 on cycles 3–5 → ch1 = 5.
3. Write ch2 = 32'hFFFF_FFFE, then evt[2] for 3 cycles:
   - SATURATE = 0 → ch2 = 1, ovf = 4'b0100, ovf_any = 1.
   - SATURATE = 1 → ch2 = 32'hFFFF_FFFF with ovf[2] set.
   - A subsequent write of 0 to ch2 clears ovf[2] and ovf_any.
4. Channel 0 holds 100 with evt[0] = 1 and snap = 1 in the same cycle; next cycle evt[0] = 0, then read → shadow read (rd_shadow = 1) = 100, live read = 101. Then write ch0 = 7 with snap, then read → shadow = 101 (pre-edge value), live = 7.
5. wr_en with wr_idx = 0 and evt[0] = 1 on the same edge, wr_data = 50 → ch0 = 50, not 51. Read with rd_idx = 3 when NUM_CNT = 3 → rd_data = 0, rd_valid = 1.
6. Counters running and a read issued, then counter_rst pulsed on the next edge → all counters, shadows, ovf and rd_data = 0; rd_valid = 0 the cycle after reset.
